// File: rtl/traffic_pkg.sv
// Shared types, light encodings and state decode for the traffic-light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      ALLRED_B = 3'd0,
      MAIN_G   = 3'd1,
      MAIN_Y   = 3'd2,
      ALLRED_A = 3'd3,
      SIDE_G   = 3'd4,
      SIDE_Y   = 3'd5,
      WALK     = 3'd6
   } state_t;

   // Lamp encodings, {R,Y,G}, one-hot
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   // Main-street lamps shown in a given state
   function automatic logic [2:0] main_dec(input state_t s);
      case (s)
         MAIN_G:  main_dec = GRN;
         MAIN_Y:  main_dec = YEL;
         default: main_dec = RED;
      endcase
   endfunction

   // Side-street lamps shown in a given state
   function automatic logic [2:0] side_dec(input state_t s);
      case (s)
         SIDE_G:  side_dec = GRN;
         SIDE_Y:  side_dec = YEL;
         default: side_dec = RED;
      endcase
   endfunction

   // Phase order; the pedestrian phase is inserted only after the second all-red
   function automatic state_t next_state(input state_t s, input logic ped);
      case (s)
         MAIN_G:   next_state = MAIN_Y;
         MAIN_Y:   next_state = ALLRED_A;
         ALLRED_A: next_state = SIDE_G;
         SIDE_G:   next_state = SIDE_Y;
         SIDE_Y:   next_state = ALLRED_B;
         ALLRED_B: next_state = ped ? WALK : MAIN_G;
         WALK:     next_state = MAIN_G;
         default:  next_state = ALLRED_B;
      endcase
   endfunction

endpackage

// File: rtl/rise_tick.sv
// Rising-edge detector: turns a slow level (already in the clk domain) into a
// one-cycle tick per rising edge. Falling edges produce nothing.
module rise_tick (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic tick
);

   logic in_q;

   // Delayed copy of the level; cleared by reset so a level held high through
   // reset release yields exactly one tick right after release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_q <= 1'b0;
      else     in_q <= in;
   end

   assign tick = in & ~in_q;

endmodule

// File: rtl/traffic_ctrl.sv
// Moore traffic-light controller for a two-way intersection with a pedestrian
// phase. Sequences the lamps in units of divided-clock ticks.
module traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int T_MAIN_GREEN = 5,
   parameter int T_SIDE_GREEN = 3,
   parameter int T_YELLOW     = 2,
   parameter int T_ALLRED     = 1,
   parameter int T_WALK       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clkdiv,
   input  logic       ped_req,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk
);

   localparam int MAX_A   = (T_MAIN_GREEN > T_SIDE_GREEN) ? T_MAIN_GREEN : T_SIDE_GREEN;
   localparam int MAX_B   = (T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED;
   localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_DUR = (MAX_AB > T_WALK) ? MAX_AB : T_WALK;
   localparam int TW      = $clog2(MAX_DUR + 1);

   state_t          state;
   state_t          nxt;
   logic [TW-1:0]   timer;
   logic            ped_pending;
   logic            tick;
   logic            last;
   logic            enter_walk;

   rise_tick u_tick (
      .clk  (clk),
      .rst  (rst),
      .in   (clkdiv),
      .tick (tick)
   );

   // Duration of each phase in ticks
   function automatic int dur(input state_t s);
      case (s)
         MAIN_G:           dur = T_MAIN_GREEN;
         SIDE_G:           dur = T_SIDE_GREEN;
         MAIN_Y, SIDE_Y:   dur = T_YELLOW;
         WALK:             dur = T_WALK;
         default:          dur = T_ALLRED;
      endcase
   endfunction

   // Phase-end detection and the state the next phase-ending tick moves to
   always_comb begin
      last       = (timer == TW'(dur(state) - 1));
      nxt        = next_state(state, ped_pending);
      enter_walk = tick & last & (nxt == WALK);
   end

   // FSM, tick timer, pedestrian latch and registered lamp decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ALLRED_B;
         timer       <= '0;
         ped_pending <= 1'b0;
         main_light  <= RED;
         side_light  <= RED;
         walk        <= 1'b0;
      end else begin
         // A request in the same cycle as WALK entry survives the clear
         ped_pending <= ped_req | (ped_pending & ~enter_walk);
         if (tick) begin
            if (last) begin
               state      <= nxt;
               timer      <= '0;
               main_light <= main_dec(nxt);
               side_light <= side_dec(nxt);
               walk       <= (nxt == WALK);
            end else begin
               timer <= timer + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: expected phase sequence kept in a
// queue and popped whenever the lamps change.
module tb_traffic_ctrl;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   localparam logic [6:0] PH_AR   = {R, R, 1'b0};
   localparam logic [6:0] PH_MG   = {G, R, 1'b0};
   localparam logic [6:0] PH_MY   = {Y, R, 1'b0};
   localparam logic [6:0] PH_SG   = {R, G, 1'b0};
   localparam logic [6:0] PH_SY   = {R, Y, 1'b0};
   localparam logic [6:0] PH_WALK = {R, R, 1'b1};

   typedef struct packed {
      logic [6:0] lights;
      int         dur;
   } exp_t;

   exp_t sbq[$];

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         rise_cyc = -10;
   int         tick_cnt = 0;
   int         cur_dur = 1;
   int         gen_ph = 0;
   bit         sb_en = 0;
   bit         gen_en = 0;
   bit         rnd_en = 0;
   logic [6:0] prev_obs = PH_AR;

   logic       clk = 1'b0;
   logic       rst;
   logic       clkdiv;
   logic       ped_req;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;

   always #5 clk = ~clk;

   traffic_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .clkdiv     (clkdiv),
      .ped_req    (ped_req),
      .main_light (main_light),
      .side_light (side_light),
      .walk       (walk)
   );

   task automatic push(input logic [6:0] l, input int d);
      exp_t e;
      e.lights = l;
      e.dur    = d;
      sbq.push_back(e);
   endtask

   // One round starting after ALLRED_B: MAIN_G .. ALLRED_B
   task automatic push_round();
      push(PH_MG, 5);
      push(PH_MY, 2);
      push(PH_AR, 1);
      push(PH_SG, 3);
      push(PH_SY, 2);
      push(PH_AR, 1);
   endtask

   // One clk: observe at negedge, check invariants and phase changes, then drive
   task automatic step();
      logic [6:0] obs;
      exp_t       e;
      logic       old;
      @(negedge clk);
      cyc++;
      obs = {main_light, side_light, walk};
      tests++;
      if (!($onehot(main_light) && $onehot(side_light))) begin
         fails++;
         $display("FAIL onehot cyc=%0d main=%b side=%b", cyc, main_light, side_light);
      end
      tests++;
      if (main_light !== R && side_light !== R) begin
         fails++;
         $display("FAIL safety cyc=%0d main=%b side=%b both non-red", cyc, main_light, side_light);
      end
      if (sb_en && obs !== prev_obs) begin
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change cyc=%0d got=%b from=%b", cyc, obs, prev_obs);
         end else begin
            e = sbq.pop_front();
            if (obs !== e.lights) begin
               fails++;
               $display("FAIL phase_lights cyc=%0d got=%b expected=%b", cyc, obs, e.lights);
            end
            tests++;
            if (tick_cnt != cur_dur) begin
               fails++;
               $display("FAIL phase_ticks cyc=%0d got=%0d expected=%0d", cyc, tick_cnt, cur_dur);
            end
            tests++;
            if (rise_cyc != cyc - 1) begin
               fails++;
               $display("FAIL latency cyc=%0d tick_at=%0d expected_tick_at=%0d", cyc, rise_cyc, cyc - 1);
            end
            cur_dur  = e.dur;
            tick_cnt = 0;
         end
      end
      prev_obs = obs;
      old = clkdiv;
      if (rnd_en) begin
         clkdiv  = 1'($urandom_range(0, 1));
         ped_req = 1'($urandom_range(0, 1));
      end else if (gen_en) begin
         clkdiv = (gen_ph < 4);
         gen_ph = (gen_ph + 1) % 8;
      end
      if (clkdiv && !old) begin
         tick_cnt++;
         rise_cyc = cyc;
      end
   endtask

   task automatic run_until_empty(input int bound, input string name);
      for (int i = 0; i < bound && sbq.size() != 0; i++) step();
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout remaining=%0d expected=0", name, sbq.size());
      end
      sbq.delete();
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      clkdiv  = 1'b0;
      ped_req = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (main_light !== R) begin
         fails++;
         $display("FAIL reset_main got=%b expected=%b", main_light, R);
      end
      tests++;
      if (side_light !== R) begin
         fails++;
         $display("FAIL reset_side got=%b expected=%b", side_light, R);
      end
      tests++;
      if (walk !== 1'b0) begin
         fails++;
         $display("FAIL reset_walk got=%b expected=0", walk);
      end
      rst      = 1'b0;
      prev_obs = PH_AR;
      cur_dur  = 1;
      tick_cnt = 0;
      gen_ph   = 0;
      gen_en   = 1;
      sb_en    = 1;
   endtask

   task automatic test_normal();
      push_round();
      push_round();
      run_until_empty(2 * 112 + 30, "normal");
   endtask

   task automatic test_ped_pulse();
      push(PH_MG, 5);
      push(PH_MY, 2);
      push(PH_AR, 1);
      push(PH_SG, 3);
      run_until_empty(150, "ped_pre");
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      push(PH_SY, 2);
      push(PH_AR, 1);
      push(PH_WALK, 4);
      push(PH_MG, 5);
      run_until_empty(150, "ped_walk");
      // Next round must skip WALK: the request was consumed
      push(PH_MY, 2);
      push(PH_AR, 1);
      push(PH_SG, 3);
      push(PH_SY, 2);
      push(PH_AR, 1);
      push(PH_MG, 5);
      run_until_empty(150, "ped_cleared");
   endtask

   task automatic test_ped_held();
      ped_req = 1'b1;
      push(PH_MY, 2);
      push(PH_AR, 1);
      push(PH_SG, 3);
      push(PH_SY, 2);
      push(PH_AR, 1);
      push(PH_WALK, 4);
      run_until_empty(150, "held_first");
      ped_req = 1'b0;
      push_round();
      push(PH_WALK, 4);
      push(PH_MG, 5);
      run_until_empty(200, "held_second");
      push(PH_MY, 2);
      push(PH_AR, 1);
      push(PH_SG, 3);
      push(PH_SY, 2);
      push(PH_AR, 1);
      push(PH_MG, 5);
      run_until_empty(150, "held_cleared");
   endtask

   task automatic test_stuck();
      push(PH_MY, 2);
      for (int i = 0; i < 100 && !(tick_cnt == 2 && clkdiv == 1'b0); i++) step();
      gen_en = 0;
      repeat (100) step();
      tests++;
      if ({main_light, side_light, walk} !== PH_MG) begin
         fails++;
         $display("FAIL stuck_frozen got=%b expected=%b", {main_light, side_light, walk}, PH_MG);
      end
      tests++;
      if (sbq.size() != 1) begin
         fails++;
         $display("FAIL stuck_no_advance queue=%0d expected=1", sbq.size());
      end
      gen_en = 1;
      run_until_empty(100, "stuck_resume");
   endtask

   task automatic test_async_reset();
      push(PH_AR, 1);
      push(PH_SG, 3);
      push(PH_SY, 2);
      run_until_empty(100, "ar_pre");
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      repeat (3) step();
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (main_light !== R) begin
         fails++;
         $display("FAIL async_rst_main got=%b expected=%b", main_light, R);
      end
      tests++;
      if (side_light !== R) begin
         fails++;
         $display("FAIL async_rst_side got=%b expected=%b", side_light, R);
      end
      tests++;
      if (walk !== 1'b0) begin
         fails++;
         $display("FAIL async_rst_walk got=%b expected=0", walk);
      end
      sbq.delete();
      gen_en = 0;
      clkdiv = 1'b1;
      repeat (3) @(negedge clk);
      // Release with clkdiv already high: exactly one tick right after release
      rst      = 1'b0;
      prev_obs = PH_AR;
      cur_dur  = 1;
      tick_cnt = 1;
      rise_cyc = cyc;
      gen_ph   = 1;
      gen_en   = 1;
      push(PH_MG, 5);
      push(PH_MY, 2);
      push(PH_AR, 1);
      push(PH_SG, 3);
      push(PH_SY, 2);
      push(PH_AR, 1);
      push(PH_MG, 5);
      run_until_empty(200, "ar_post");
   endtask

   task automatic test_random();
      sb_en  = 0;
      rnd_en = 1;
      repeat (10000) step();
      rnd_en  = 0;
      ped_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_ped_pulse();
      test_ped_held();
      test_stuck();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
